// File: rtl/stream_pkg.sv
// Shared definitions for the stream FIFO slice: EOT bit positions and
// occupancy counter sizing.
package stream_pkg;

    localparam int EOT_LINE = 0;

    function automatic int eot_frame_idx(input int w_eot);
        return w_eot - 1;
    endfunction

    // Occupancy must hold DEPTH memory entries plus one output-slot beat.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready beat stream with data and EOT sideband.
interface stream_fifo_if
    import stream_pkg::*;
#(
    parameter int W_DATA = 8,
    parameter int W_EOT  = 2
);
    logic              valid;
    logic              ready;
    logic [W_DATA-1:0] data;
    logic [W_EOT-1:0]  eot;

    modport master (output valid, output data, output eot, input ready);
    modport slave  (input valid, input data, input eot, output ready);

endinterface

// File: rtl/stream_fifo_outreg.sv
// Registered output slot: refills from memory whenever empty or being consumed.
module stream_fifo_outreg
    import stream_pkg::*;
#(
    parameter int WB = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          avail,
    input  logic          ready,
    input  logic [WB-1:0] beat,
    output logic          valid,
    output logic          load,
    output logic          valid_nxt,
    output logic [WB-1:0] beat_out
);

    logic          valid_r;
    logic [WB-1:0] beat_r;
    logic          consume_s;
    logic          load_s;
    logic          valid_nxt_s;

    assign consume_s = valid_r & ready;
    assign load_s    = (~valid_r | consume_s) & avail & ~clear;

    // Next slot occupancy; a clear empties the slot even if a load was possible
    always_comb begin
        valid_nxt_s = valid_r;
        if (clear) begin
            valid_nxt_s = 1'b0;
        end else if (load_s) begin
            valid_nxt_s = 1'b1;
        end else if (consume_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Slot valid and beat registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            beat_r  <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            if (load_s) begin
                beat_r <= beat;
            end
        end
    end

    assign valid     = valid_r;
    assign load      = load_s;
    assign valid_nxt = valid_nxt_s;
    assign beat_out  = beat_r;

endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO with zero preload, flush (explicit or on frame EOT), registered
// occupancy/threshold flags and an optional registered output slot.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int W_DATA       = 8,
    parameter int W_EOT        = 2,
    parameter int DEPTH        = 32,
    parameter int PRELOAD      = 4,
    parameter int AF_LEVEL     = DEPTH - 2,
    parameter int AE_LEVEL     = 2,
    parameter int FLUSH_ON_EOT = 1,
    parameter int OUT_REG      = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    stream_fifo_if.slave                  din,
    stream_fifo_if.master                 dout,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          almost_full,
    output logic                          almost_empty
);

    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = count_width(DEPTH);
    localparam int WB        = W_DATA + W_EOT;
    localparam int EOT_FRAME = eot_frame_idx(W_EOT);

    localparam logic [AW:0]   PTR_ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   PTR_PRELOAD = (AW+1)'(PRELOAD);
    localparam logic [CW-1:0] CNT_PRELOAD = CW'(PRELOAD);
    localparam logic [CW-1:0] AF_CMP      = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CMP      = CW'(AE_LEVEL);

    logic [WB-1:0] mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [AW:0]   wr_ptr_nxt_s;
    logic [AW:0]   rd_ptr_nxt_s;
    logic [AW:0]   ptr_diff_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          af_r;
    logic          ae_r;
    logic          mem_empty_s;
    logic          mem_full_s;
    logic          wr_acc_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          flush_evt_s;
    logic          slot_valid_nxt_s;
    logic [WB-1:0] head_s;

    assign mem_empty_s = (wr_ptr_r == rd_ptr_r);
    assign mem_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                         (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s      = mem_r[rd_ptr_r[AW-1:0]];

    // A frame-end beat that triggers a flush is consumed but never stored.
    assign wr_acc_s    = din.valid & din.ready;
    assign flush_evt_s = flush | ((FLUSH_ON_EOT != 0) & wr_acc_s & din.eot[EOT_FRAME]);
    assign wr_en_s     = wr_acc_s & ~flush_evt_s;

    generate
        if (OUT_REG != 0) begin : g_outreg
            logic          slot_valid_s;
            logic [WB-1:0] slot_beat_s;

            stream_fifo_outreg #(
                .WB (WB)
            ) u_outreg (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (flush_evt_s),
                .avail     (~mem_empty_s),
                .ready     (dout.ready),
                .beat      (head_s),
                .valid     (slot_valid_s),
                .load      (rd_en_s),
                .valid_nxt (slot_valid_nxt_s),
                .beat_out  (slot_beat_s)
            );

            assign din.ready  = ~mem_full_s;
            assign dout.valid = slot_valid_s;
            assign dout.data  = slot_beat_s[WB-1:W_EOT];
            assign dout.eot   = slot_beat_s[W_EOT-1:0];
        end else begin : g_direct
            // When full, a concurrent read frees the entry being written.
            assign rd_en_s          = ~mem_empty_s & dout.ready;
            assign slot_valid_nxt_s = 1'b0;
            assign din.ready        = ~mem_full_s | dout.ready;
            assign dout.valid       = ~mem_empty_s;
            assign dout.data        = head_s[WB-1:W_EOT];
            assign dout.eot         = head_s[W_EOT-1:0];
        end
    endgenerate

    // Next pointer values; flush rewinds to the preloaded zero window
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (flush_evt_s) begin
            wr_ptr_nxt_s = PTR_PRELOAD;
            rd_ptr_nxt_s = '0;
        end else begin
            wr_ptr_nxt_s = wr_en_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_nxt_s = rd_en_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        end
    end

    // Difference taken at pointer width so wrap-around stays modulo 2*DEPTH.
    assign ptr_diff_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    assign count_nxt_s = {1'b0, ptr_diff_s} + {{(CW-1){1'b0}}, slot_valid_nxt_s};

    // Pointers, occupancy and threshold flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_PRELOAD;
            rd_ptr_r <= '0;
            count_r  <= CNT_PRELOAD;
            af_r     <= (CNT_PRELOAD >= AF_CMP);
            ae_r     <= (CNT_PRELOAD <= AE_CMP);
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            af_r     <= (count_nxt_s >= AF_CMP);
            ae_r     <= (count_nxt_s <= AE_CMP);
        end
    end

    // Beat storage; flush rewrites the preload window with zero beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush_evt_s) begin
            for (int i = 0; i < PRELOAD; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {din.data, din.eot};
        end
    end

    assign count        = count_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: one direct-output and one registered-output instance
// driven by shared stimulus, each scored against a queue model of its contents.
module tb_stream_fifo;
    import stream_pkg::*;

    localparam int W_DATA   = 8;
    localparam int W_EOT    = 2;
    localparam int DEPTH    = 8;
    localparam int PRELOAD  = 2;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int AE_LEVEL = 2;
    localparam int CW       = count_width(DEPTH);

    typedef logic [W_DATA+W_EOT-1:0] beat_t;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b1;
    logic              flush      = 1'b0;
    logic              din_valid  = 1'b0;
    logic              dout_ready = 1'b0;
    logic [W_DATA-1:0] din_data   = '0;
    logic [W_EOT-1:0]  din_eot    = '0;

    int checks = 0;
    int errors = 0;

    logic          dv   [2];
    logic          drdy [2];
    beat_t         dbeat[2];
    logic [CW-1:0] cnt  [2];
    logic          af   [2];
    logic          ae   [2];

    beat_t mq   [2][$];
    logic  hold [2];
    beat_t held [2];

    always #5 clk = ~clk;

    stream_fifo_if #(.W_DATA(W_DATA), .W_EOT(W_EOT)) in0 ();
    stream_fifo_if #(.W_DATA(W_DATA), .W_EOT(W_EOT)) out0 ();
    stream_fifo_if #(.W_DATA(W_DATA), .W_EOT(W_EOT)) in1 ();
    stream_fifo_if #(.W_DATA(W_DATA), .W_EOT(W_EOT)) out1 ();

    assign in0.valid  = din_valid;
    assign in0.data   = din_data;
    assign in0.eot    = din_eot;
    assign out0.ready = dout_ready;
    assign in1.valid  = din_valid;
    assign in1.data   = din_data;
    assign in1.eot    = din_eot;
    assign out1.ready = dout_ready;

    assign dv[0]    = out0.valid;
    assign drdy[0]  = in0.ready;
    assign dbeat[0] = {out0.data, out0.eot};
    assign dv[1]    = out1.valid;
    assign drdy[1]  = in1.ready;
    assign dbeat[1] = {out1.data, out1.eot};

    stream_fifo #(
        .W_DATA(W_DATA), .W_EOT(W_EOT), .DEPTH(DEPTH), .PRELOAD(PRELOAD),
        .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FLUSH_ON_EOT(1), .OUT_REG(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(in0), .dout(out0),
        .count(cnt[0]), .almost_full(af[0]), .almost_empty(ae[0])
    );

    stream_fifo #(
        .W_DATA(W_DATA), .W_EOT(W_EOT), .DEPTH(DEPTH), .PRELOAD(PRELOAD),
        .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FLUSH_ON_EOT(1), .OUT_REG(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .din(in1), .dout(out1),
        .count(cnt[1]), .almost_full(af[1]), .almost_empty(ae[1])
    );

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d]: actual=0x%0h expected=0x%0h", name, id, act, exp);
        end
    endtask

    task automatic model_reset(input int id);
        mq[id].delete();
        for (int k = 0; k < PRELOAD; k++) mq[id].push_back('0);
        hold[id] = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_count", 0, 32'(cnt[0]), 32'(PRELOAD));
        check("rst_dout_valid", 0, 32'(dv[0]), 32'd1);
        check("rst_dout_beat", 0, 32'(dbeat[0]), 32'd0);
        check("rst_din_ready", 0, 32'(drdy[0]), 32'd1);
        check("rst_almost_full", 0, 32'(af[0]), 32'd0);
        check("rst_almost_empty", 0, 32'(ae[0]), 32'd1);
        check("rst_count", 1, 32'(cnt[1]), 32'(PRELOAD));
        check("rst_dout_valid", 1, 32'(dv[1]), 32'd0);
        check("rst_din_ready", 1, 32'(drdy[1]), 32'd1);
    endtask

    // Scoreboard monitor: status vs model, read beats popped, accepted beats pushed
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            for (int id = 0; id < 2; id++) begin
                int   sz;
                logic exp_rdy;
                logic fl;
                sz = mq[id].size();
                check("count", id, 32'(cnt[id]), 32'(sz));
                check("almost_full", id, 32'(af[id]), 32'(sz >= AF_LEVEL));
                check("almost_empty", id, 32'(ae[id]), 32'(sz <= AE_LEVEL));
                // Registered-output mode: slot holds the head, so memory is full only beyond DEPTH beats.
                exp_rdy = (id == 0) ? ((sz < DEPTH) || dout_ready) : (sz <= DEPTH);
                check("din_ready", id, 32'(drdy[id]), 32'(exp_rdy));
                if (id == 0) check("dout_valid", id, 32'(dv[id]), 32'(sz > 0));
                else if (sz == 0) check("dout_valid_empty", id, 32'(dv[id]), 32'd0);
                if (hold[id]) begin
                    check("stall_valid", id, 32'(dv[id]), 32'd1);
                    check("stall_beat", id, 32'(dbeat[id]), 32'(held[id]));
                end
                hold[id] = dv[id] && !dout_ready;
                held[id] = dbeat[id];
                if (dv[id] && dout_ready) begin
                    if (sz == 0) check("read_while_empty", id, 32'(dv[id]), 32'd0);
                    else check("dout_beat", id, 32'(dbeat[id]), 32'(mq[id].pop_front()));
                end
                fl = flush || (din_valid && drdy[id] && din_eot[W_EOT-1]);
                if (fl) model_reset(id);
                else if (din_valid && drdy[id]) mq[id].push_back({din_data, din_eot});
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst_n      = 1'b1;
        dout_ready = 1'b1;
        cycle();
        cycle();
        check("drained_count", 0, 32'(cnt[0]), 32'd0);
        check("drained_valid", 0, 32'(dv[0]), 32'd0);
        cycle();
        cycle();
        dout_ready = 1'b0;

        // Latency: beat presented after edge N is captured at N+1.
        din_valid = 1'b1;
        din_data  = 8'hAA;
        din_eot   = 2'b00;
        cycle();
        din_valid = 1'b0;
        check("lat_valid", 0, 32'(dv[0]), 32'd1);
        check("lat_valid_early", 1, 32'(dv[1]), 32'd0);
        check("lat_count", 1, 32'(cnt[1]), 32'd1);
        cycle();
        check("lat_valid", 1, 32'(dv[1]), 32'd1);
        check("lat_beat", 1, 32'(dbeat[1]), 32'({8'hAA, 2'b00}));
        check("lat_count_slot", 1, 32'(cnt[1]), 32'd1);
        dout_ready = 1'b1;
        cycle();
        cycle();
        dout_ready = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            din_valid = 1'b1;
            din_data  = 8'(8'h10 + i);
            cycle();
        end
        din_valid = 1'b0;
        check("full_din_ready", 0, 32'(drdy[0]), 32'd0);
        check("full_count", 0, 32'(cnt[0]), 32'(DEPTH));
        check("full_almost_full", 0, 32'(af[0]), 32'd1);

        din_valid  = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din_data = 8'(8'h20 + i);
            cycle();
            check("stream_count", 0, 32'(cnt[0]), 32'(DEPTH));
        end
        din_valid = 1'b0;
        repeat (12) cycle();
        dout_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            din_valid = 1'b1;
            din_data  = 8'(8'h30 + i);
            din_eot   = 2'(i % 2);
            cycle();
        end
        din_data = 8'h3F;
        din_eot  = 2'b10;
        cycle();
        din_valid = 1'b0;
        din_eot   = 2'b00;
        check("eot_flush_count", 0, 32'(cnt[0]), 32'(PRELOAD));
        check("eot_flush_beat", 0, 32'(dbeat[0]), 32'd0);
        check("eot_flush_count", 1, 32'(cnt[1]), 32'(PRELOAD));
        dout_ready = 1'b1;
        repeat (4) cycle();

        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                rst_n = 1'b0;
                #1;
                check_reset();
                @(negedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            din_data   = 8'($urandom);
            din_eot    = {($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1))};
            flush      = ($urandom_range(0, 63) == 0);
            cycle();
        end
        din_valid  = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b1;
        repeat (12) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
